gemm_stream_adapter: RTL and testbench
======================================

# gemm_stream_adapter

Streaming front/back end for the GEMM small-DFT datapath. It accepts one complex SFP sample per cycle on a valid/ready stream and packs four samples into the 4-lane `input_real`/`input_imag` bus. It issues `start`/`control` to GEMM, tracks GEMM's fixed, non-stallable pipeline latency, and captures results into a frame FIFO. It then re-serialises the results onto a valid/ready output stream with backpressure. GEMM has no stall, so issue is credit-gated on free FIFO space.

## Interface

Parameters:
- expWidth, `EXPWIDTH (4): SFP exponent width
- sigWidth, `SIGWIDTH (4): SFP mantissa width
- formatWidth, `SFPWIDTH (9): SFP word width
- GEMM_LAT, `GEMM_LATENCY (5): cycles from GEMM input to GEMM output
- DEPTH, 4: output FIFO depth in frames (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&s_ready
- s_real, s_imag  in  formatWidth  input sample
- s_mode  in  1  1 = size4, 0 = two size2; sampled with lane-0 sample only
- g_start  out  1  one-cycle issue strobe to GEMM
- g_control  out  1  GEMM `control`
- g_in_real, g_in_imag  out  4*formatWidth  GEMM input bus; lane k at bits [formatWidth*(k+1)-1 : formatWidth*k]
- g_out_real, g_out_imag  in  4*formatWidth  GEMM output bus
- m_valid  out  1  output sample valid
- m_ready  in  1  output sample consumed when m_valid&m_ready
- m_real, m_imag  out  formatWidth  output sample
- m_last  out  1  high on lane-3 sample of a frame
- m_mode  out  1  mode of the frame being output

## Operation

- Packer: lane counter cnt (0..4) and pack buffer; the k-th accepted sample of a frame goes into lane k. s_ready = (cnt<4).
- Issue condition: frame complete, reserved<DEPTH, and (frame mode == g_control, or no frame in flight). GEMM reads `control` in several stages, so a mode change waits until the latency tracker is empty.
- Issue edge: load g_in_* from the pack buffer, set g_control to the frame mode, and pulse g_start high for exactly one cycle. reserved++. The tracker shift register (GEMM_LAT bits plus mode) gets a 1.
- Back-to-back issue: if the 4th sample is accepted on an edge where the issue condition holds, the frame issues on that same edge and cnt→0. Otherwise cnt=4 (s_ready=0) until the frame issues.
- g_in_*/g_control hold their value between issues.
- Capture: when the tracker tail is 1, {g_out_real, g_out_imag, mode} is written to the FIFO on that edge. The credit scheme guarantees the FIFO is never full at that point; a write to a full FIFO is an assertion failure.
- Unpacker: the head frame is presented lane 0..3 on m_real/m_imag. The lane index advances on m_valid&m_ready. The frame pops on lane 3, with m_last=1.
- reserved is decremented on pop. Simultaneous issue and pop leaves reserved unchanged.
- m_valid = FIFO not empty. All outputs are register-driven or derived from registers only; no combinational path from s_valid to m_*.

## Timing

- Reset values: s_ready=1, g_start=0, g_control=0, g_in_*=0, m_valid=0, m_last=0, m_mode=0, m_real/m_imag=0. cnt, reserved, tracker, FIFO and lane index are all cleared.
- g_start is high in cycle T. The result is captured at the end of cycle T+GEMM_LAT.
- First output sample: m_valid rises in cycle T+GEMM_LAT+1.
- Sustained throughput is 1 sample/cycle in and out when m_ready=1 and mode is constant.
- Reset mid-operation: GEMM shares rst. All in-flight and buffered frames are discarded, and a partially packed frame is dropped.
- m_ready=0 indefinitely: the FIFO fills and issue stops at reserved==DEPTH, then s_ready drops once the pack buffer is full. No result is ever lost.
- m_real/m_imag/m_last must be stable while m_valid&!m_ready.

## Structure

- `parameter.vh`: add `GEMM_LATENCY` (5) alongside the existing `EXPWIDTH`/`SIGWIDTH`/`SFPWIDTH`/`LOW_EXPAND`.
- Sub-module `gemm_frame_fifo`: synchronous FIFO, DEPTH entries × (8*formatWidth+1). Interface: wr_en/din, rd_en/dout, empty/full/count; asynchronous active-low rst.
- The top level holds the packer, issue/credit logic, latency tracker and unpacker.

## Test plan

The bench replaces GEMM with an identity model: out = in delayed GEMM_LAT cycles, outputs cleared on rst.
- Samples 0x001..0x004 real / 0x101..0x104 imag, mode 1, m_ready=1 → g_start once with g_in_real=={0x004,0x003,0x002,0x001} (lane3..lane0) and g_control=1. Outputs 0x001..0x004 appear in order starting 6 cycles after g_start's cycle... i.e. T+GEMM_LAT+1, with m_last on 0x004.
- 16 consecutive samples, mode 0, s_valid and m_ready held high → 4 g_start pulses spaced 4 cycles apart, s_ready never drops, and 16 outputs in order.
- m_ready=0 with 24 samples offered → exactly 4 frames issued (reserved==4), s_ready=0 after the 20th sample. Releasing m_ready then drains all 24 samples in order with no loss.
- Frame A mode 1 then frame B mode 0, back to back → B's g_start is delayed until A's tracker bit retires. g_control switches only with B's g_start, and m_mode follows per frame.
- rst asserted 2 cycles after a g_start, mid-frame → all outputs return to reset values immediately. After release, no stale frame appears, and a new frame round-trips correctly.
- m_ready toggling 1/0 every cycle → m_real is stable whenever m_valid&!m_ready, and the sequence is intact.

Source files
------------

// File: rtl/gemm_stream_adapter_pkg.sv
// Shared constants for the GEMM stream adapter: lane count, default widths and
// the width of one buffered result frame.
package gemm_stream_adapter_pkg;

    localparam int NUM_LANES        = 4;
    localparam int DEF_EXP_WIDTH    = 4;
    localparam int DEF_SIG_WIDTH    = 4;
    localparam int DEF_GEMM_LATENCY = 5;
    localparam int DEF_DEPTH        = 4;

    // One frame entry holds all real lanes, all imag lanes and the frame mode.
    function automatic int entry_width(input int fw);
        return 2 * NUM_LANES * fw + 1;
    endfunction

endpackage

// File: rtl/gemm_frame_fifo.sv
// Synchronous frame FIFO for captured GEMM results, DEPTH entries of WIDTH bits.
// Storage is cleared on reset so dout reads as zero until the first write.
module gemm_frame_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && !full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/gemm_stream_adapter.sv
// Stream front/back end for the GEMM small-DFT datapath: packs four samples per
// frame, issues credit-gated GEMM starts, captures results and re-serialises them.
module gemm_stream_adapter
    import gemm_stream_adapter_pkg::*;
#(
    parameter int expWidth    = DEF_EXP_WIDTH,
    parameter int sigWidth    = DEF_SIG_WIDTH,
    parameter int formatWidth = expWidth + sigWidth + 1,
    parameter int GEMM_LAT    = DEF_GEMM_LATENCY,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [formatWidth-1:0]           s_real,
    input  logic [formatWidth-1:0]           s_imag,
    input  logic                             s_mode,
    output logic                             g_start,
    output logic                             g_control,
    output logic [NUM_LANES*formatWidth-1:0] g_in_real,
    output logic [NUM_LANES*formatWidth-1:0] g_in_imag,
    input  logic [NUM_LANES*formatWidth-1:0] g_out_real,
    input  logic [NUM_LANES*formatWidth-1:0] g_out_imag,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [formatWidth-1:0]           m_real,
    output logic [formatWidth-1:0]           m_imag,
    output logic                             m_last,
    output logic                             m_mode
);

    localparam int ENTRY_W = entry_width(formatWidth);
    localparam int RES_W   = $clog2(DEPTH + 1);

    logic [2:0]                                 cnt;
    logic [NUM_LANES-1:0][formatWidth-1:0]      pk_real;
    logic [NUM_LANES-1:0][formatWidth-1:0]      pk_imag;
    logic [NUM_LANES-1:0][formatWidth-1:0]      frame_real;
    logic [NUM_LANES-1:0][formatWidth-1:0]      frame_imag;
    logic                                       pk_mode;
    logic                                       accept;
    logic                                       frame_full;
    logic                                       busy;
    logic                                       issue;
    logic                                       capture;
    logic                                       pop;
    logic [GEMM_LAT-1:0]                        trk;
    logic [RES_W-1:0]                           reserved;
    logic [RES_W-1:0]                           fifo_count;
    logic [1:0]                                 lane;
    logic                                       fifo_empty;
    logic                                       fifo_full;
    logic [ENTRY_W-1:0]                         fifo_din;
    logic [ENTRY_W-1:0]                         fifo_dout;
    logic [NUM_LANES-1:0][formatWidth-1:0]      out_real;
    logic [NUM_LANES-1:0][formatWidth-1:0]      out_imag;
    logic                                       out_mode;

    // A frame may issue on the same edge its 4th sample arrives; a mode change
    // must wait for an empty pipeline because GEMM samples control in several stages.
    always_comb begin
        s_ready    = (cnt < 3'd4);
        accept     = s_valid && s_ready;
        frame_full = (cnt == 3'd4) || ((cnt == 3'd3) && accept);
        frame_real = pk_real;
        frame_imag = pk_imag;
        if (cnt == 3'd3) begin
            frame_real[3] = s_real;
            frame_imag[3] = s_imag;
        end
        busy    = g_start || (trk != '0);
        issue   = frame_full && (reserved < RES_W'(DEPTH)) && ((pk_mode == g_control) || !busy);
        capture = trk[GEMM_LAT-1];
        pop     = m_valid && m_ready && (lane == 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            pk_real <= '0;
            pk_imag <= '0;
            pk_mode <= 1'b0;
        end else begin
            if (accept) begin
                pk_real[cnt[1:0]] <= s_real;
                pk_imag[cnt[1:0]] <= s_imag;
                if (cnt == 3'd0) begin
                    pk_mode <= s_mode;
                end
            end
            if (issue) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // reserved counts frames issued but not yet fully output, so capture never overflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_start   <= 1'b0;
            g_control <= 1'b0;
            g_in_real <= '0;
            g_in_imag <= '0;
            trk       <= '0;
            reserved  <= '0;
        end else begin
            g_start <= issue;
            trk     <= (trk << 1) | GEMM_LAT'(g_start);
            if (issue) begin
                g_in_real <= frame_real;
                g_in_imag <= frame_imag;
                g_control <= pk_mode;
            end
            case ({issue, pop})
                2'b10:   reserved <= reserved + RES_W'(1);
                2'b01:   reserved <= reserved - RES_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane <= '0;
        end else if (m_valid && m_ready) begin
            lane <= lane + 2'd1;
        end
    end

    // Every in-flight frame shares g_control, so it doubles as the tracker's mode bit.
    assign fifo_din = {g_out_real, g_out_imag, g_control};

    gemm_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (capture),
        .din   (fifo_din),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign {out_real, out_imag, out_mode} = fifo_dout;
    assign m_valid = !fifo_empty;
    assign m_real  = out_real[lane];
    assign m_imag  = out_imag[lane];
    assign m_mode  = out_mode;
    assign m_last  = m_valid && (lane == 2'd3);

    assert property (@(posedge clk) disable iff (!rst) capture |-> !fifo_full);
    assert property (@(posedge clk) disable iff (!rst) fifo_count <= reserved);

endmodule

// File: tb/tb_gemm_stream_adapter.sv
// Bench for gemm_stream_adapter with an identity GEMM model; outputs are checked
// against a frame-level reference built from accepted samples.
module tb_gemm_stream_adapter;

    localparam int F     = 9;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    typedef struct { logic [F-1:0] re; logic [F-1:0] im; logic mode; } sample_t;
    typedef struct { logic [4*F-1:0] re; logic [4*F-1:0] im; logic mode; } frame_t;
    typedef struct { logic [F-1:0] re; logic [F-1:0] im; logic last; logic mode; } out_t;
    typedef struct {
        logic [F-1:0] inRe; logic [F-1:0] inIm; logic inMode;
        logic [F-1:0] expRe; logic [F-1:0] expIm; logic expLast; logic expMode;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [F-1:0]   s_real;
    logic [F-1:0]   s_imag;
    logic           s_mode;
    logic           g_start;
    logic           g_control;
    logic [4*F-1:0] g_in_real;
    logic [4*F-1:0] g_in_imag;
    logic [4*F-1:0] g_out_real;
    logic [4*F-1:0] g_out_imag;
    logic           m_valid;
    logic           m_ready;
    logic [F-1:0]   m_real;
    logic [F-1:0]   m_imag;
    logic           m_last;
    logic           m_mode;

    gemm_stream_adapter #(
        .expWidth    (4),
        .sigWidth    (4),
        .formatWidth (F),
        .GEMM_LAT    (LAT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .s_mode     (s_mode),
        .g_start    (g_start),
        .g_control  (g_control),
        .g_in_real  (g_in_real),
        .g_in_imag  (g_in_imag),
        .g_out_real (g_out_real),
        .g_out_imag (g_out_imag),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_real     (m_real),
        .m_imag     (m_imag),
        .m_last     (m_last),
        .m_mode     (m_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Identity GEMM: output equals input delayed LAT cycles, cleared on reset.
    logic [4*F-1:0] pipeRe [LAT];
    logic [4*F-1:0] pipeIm [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) begin
                pipeRe[k] <= '0;
                pipeIm[k] <= '0;
            end
        end else begin
            pipeRe[0] <= g_in_real;
            pipeIm[0] <= g_in_imag;
            for (int k = 1; k < LAT; k++) begin
                pipeRe[k] <= pipeRe[k-1];
                pipeIm[k] <= pipeIm[k-1];
            end
        end
    end
    assign g_out_real = pipeRe[LAT-1];
    assign g_out_imag = pipeIm[LAT-1];

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      firstValid = -1;
    int      acceptCnt = 0;
    bit      sReadyDrop = 0;
    bit      prevHold = 0;
    logic    prevControl = 1'b0;
    logic [F-1:0] heldRe;
    logic [F-1:0] heldIm;
    logic    heldLast;
    sample_t feed [$];
    sample_t pend [$];
    frame_t  issueQ [$];
    out_t    outQ [$];
    out_t    outLog [$];
    int      startCyc [$];
    vec_t    vecs [8];

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    task automatic clearTrack();
        startCyc.delete();
        outLog.delete();
        firstValid = -1;
        sReadyDrop = 0;
        acceptCnt  = 0;
    endtask

    task automatic checkResetValues(input string p);
        checkEq({p, "_s_ready"}, s_ready, 1);
        checkEq({p, "_g_start"}, g_start, 0);
        checkEq({p, "_g_control"}, g_control, 0);
        checkEq({p, "_g_in_real"}, g_in_real, 0);
        checkEq({p, "_g_in_imag"}, g_in_imag, 0);
        checkEq({p, "_m_valid"}, m_valid, 0);
        checkEq({p, "_m_last"}, m_last, 0);
        checkEq({p, "_m_mode"}, m_mode, 0);
        checkEq({p, "_m_real"}, m_real, 0);
        checkEq({p, "_m_imag"}, m_imag, 0);
    endtask

    // Samples outputs mid-cycle, updates the reference model and advances one cycle.
    task automatic step(output bit accepted);
        frame_t  fr;
        out_t    o;
        sample_t smp;
        accepted = 0;
        #1;
        if (rst) begin
            if (prevHold) begin
                checkEq("hold_valid", m_valid, 1);
                checkEq("hold_real", m_real, heldRe);
                checkEq("hold_imag", m_imag, heldIm);
                checkEq("hold_last", m_last, heldLast);
            end
            if (g_control !== prevControl) checkEq("control_changes_with_start", g_start, 1);
            prevControl = g_control;
            if (g_start) begin
                startCyc.push_back(cyc);
                if (issueQ.size() == 0) failNow("g_start_unexpected");
                else begin
                    fr = issueQ.pop_front();
                    checkEq("g_in_real", g_in_real, fr.re);
                    checkEq("g_in_imag", g_in_imag, fr.im);
                    checkEq("g_control", g_control, fr.mode);
                end
            end
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (s_valid && !s_ready) sReadyDrop = 1;
            if (m_valid && m_ready) begin
                o.re = m_real; o.im = m_imag; o.last = m_last; o.mode = m_mode;
                outLog.push_back(o);
                if (outQ.size() == 0) failNow("output_unexpected");
                else begin
                    o = outQ.pop_front();
                    checkEq("m_real", m_real, o.re);
                    checkEq("m_imag", m_imag, o.im);
                    checkEq("m_last", m_last, o.last);
                    checkEq("m_mode", m_mode, o.mode);
                end
            end
            prevHold = m_valid && !m_ready;
            heldRe = m_real; heldIm = m_imag; heldLast = m_last;
            if (s_valid && s_ready) begin
                accepted = 1;
                acceptCnt++;
                smp.re = s_real; smp.im = s_imag; smp.mode = s_mode;
                pend.push_back(smp);
                if (pend.size() == 4) begin
                    for (int k = 0; k < 4; k++) begin
                        fr.re[k*F +: F] = pend[k].re;
                        fr.im[k*F +: F] = pend[k].im;
                        o.re = pend[k].re; o.im = pend[k].im;
                        o.last = (k == 3); o.mode = pend[0].mode;
                        outQ.push_back(o);
                    end
                    fr.mode = pend[0].mode;
                    issueQ.push_back(fr);
                    pend.delete();
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // mrMode: 0 ready high, 1 toggle, 2 random, 3 ready low.
    task automatic driveOne(input int mrMode, input int validPct);
        bit acc;
        s_valid = (feed.size() > 0) && ($urandom_range(99) < validPct);
        if (feed.size() > 0) begin
            s_real = feed[0].re; s_imag = feed[0].im; s_mode = feed[0].mode;
        end
        case (mrMode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(1));
            default: m_ready = 1'b0;
        endcase
        step(acc);
        if (acc) feed.delete(0);
    endtask

    task automatic runStream(input int maxCycles, input int mrMode, input int validPct, input bit untilDrained);
        int n = 0;
        while (1) begin
            if (untilDrained && feed.size() == 0 && outQ.size() == 0 && issueQ.size() == 0) break;
            if (n >= maxCycles) begin
                if (untilDrained) failNow("drain_timeout");
                break;
            end
            driveOne(mrMode, validPct);
            n++;
        end
        s_valid = 1'b0;
    endtask

    task automatic addFrame(input logic mode, input logic [F-1:0] baseRe, input logic [F-1:0] baseIm);
        sample_t smp;
        for (int k = 0; k < 4; k++) begin
            smp.re = baseRe + F'(k); smp.im = baseIm + F'(k); smp.mode = mode;
            feed.push_back(smp);
        end
    endtask

    task automatic addRandomFrames(input int n);
        sample_t smp;
        for (int i = 0; i < 4 * n; i++) begin
            smp.re = F'($urandom_range(511));
            smp.im = F'($urandom_range(511));
            smp.mode = 1'($urandom_range(1));
            feed.push_back(smp);
        end
    endtask

    task automatic applyStimulus();
        int n;
        sample_t smp;

        vecs[0] = '{9'h001, 9'h101, 1'b1, 9'h001, 9'h101, 1'b0, 1'b1};
        vecs[1] = '{9'h002, 9'h102, 1'b1, 9'h002, 9'h102, 1'b0, 1'b1};
        vecs[2] = '{9'h003, 9'h103, 1'b1, 9'h003, 9'h103, 1'b0, 1'b1};
        vecs[3] = '{9'h004, 9'h104, 1'b1, 9'h004, 9'h104, 1'b1, 1'b1};
        vecs[4] = '{9'h1F0, 9'h0AA, 1'b1, 9'h1F0, 9'h0AA, 1'b0, 1'b1};
        vecs[5] = '{9'h1F1, 9'h0AB, 1'b0, 9'h1F1, 9'h0AB, 1'b0, 1'b1};
        vecs[6] = '{9'h1F2, 9'h0AC, 1'b0, 9'h1F2, 9'h0AC, 1'b0, 1'b1};
        vecs[7] = '{9'h1F3, 9'h0AD, 1'b0, 9'h1F3, 9'h0AD, 1'b1, 1'b1};

        rst = 1'b0; s_valid = 1'b0; s_real = '0; s_imag = '0; s_mode = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;

        clearTrack();
        for (int i = 0; i < 8; i++) begin
            smp.re = vecs[i].inRe; smp.im = vecs[i].inIm; smp.mode = vecs[i].inMode;
            feed.push_back(smp);
        end
        runStream(200, 0, 100, 1);
        checkEq("table_output_count", outLog.size(), 8);
        for (int i = 0; i < 8 && i < outLog.size(); i++) begin
            checkEq($sformatf("table_real_%0d", i), outLog[i].re, vecs[i].expRe);
            checkEq($sformatf("table_imag_%0d", i), outLog[i].im, vecs[i].expIm);
            checkEq($sformatf("table_last_%0d", i), outLog[i].last, vecs[i].expLast);
            checkEq($sformatf("table_mode_%0d", i), outLog[i].mode, vecs[i].expMode);
        end
        checkEq("table_starts", startCyc.size(), 2);
        if (startCyc.size() > 0) checkEq("start_to_valid_latency", firstValid - startCyc[0], LAT + 1);

        clearTrack();
        for (int f = 0; f < 4; f++) addFrame(1'b0, F'(9'h020 + 4 * f), F'(9'h120 + 4 * f));
        runStream(200, 0, 100, 1);
        checkEq("stream_starts", startCyc.size(), 4);
        for (int i = 1; i < startCyc.size(); i++) checkEq("stream_start_spacing", startCyc[i] - startCyc[i-1], 4);
        checkEq("stream_s_ready_drop", sReadyDrop, 0);
        checkEq("stream_outputs", outLog.size(), 16);

        clearTrack();
        for (int f = 0; f < 6; f++) addFrame(1'b0, F'(9'h060 + 4 * f), F'(9'h160 + 4 * f));
        runStream(60, 3, 100, 0);
        checkEq("backpressure_starts", startCyc.size(), 4);
        checkEq("backpressure_accepted", acceptCnt, 20);
        checkEq("backpressure_s_ready", s_ready, 0);
        runStream(400, 0, 100, 1);
        checkEq("backpressure_drained", outLog.size(), 24);

        clearTrack();
        addFrame(1'b1, 9'h0C0, 9'h1C0);
        addFrame(1'b0, 9'h0D0, 9'h1D0);
        runStream(200, 0, 100, 1);
        checkEq("modeswitch_starts", startCyc.size(), 2);
        if (startCyc.size() == 2) checkEq("modeswitch_delay", (startCyc[1] - startCyc[0]) > LAT, 1);
        if (outLog.size() == 8) begin
            checkEq("modeswitch_mode_a", outLog[0].mode, 1);
            checkEq("modeswitch_mode_b", outLog[4].mode, 0);
        end else failNow("modeswitch_outputs");

        clearTrack();
        addFrame(1'b1, 9'h050, 9'h150);
        smp.re = 9'h0EE; smp.im = 9'h1EE; smp.mode = 1'b0;
        feed.push_back(smp);
        feed.push_back(smp);
        n = 0;
        while (startCyc.size() == 0 && n < 50) begin
            driveOne(0, 100);
            n++;
        end
        if (startCyc.size() == 0) failNow("midreset_no_start");
        repeat (2) driveOne(0, 100);
        rst = 1'b0;
        s_valid = 1'b0;
        #1;
        checkResetValues("midreset");
        feed.delete(); pend.delete(); issueQ.delete(); outQ.delete();
        prevHold = 0; prevControl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst = 1'b1;
        clearTrack();
        runStream(20, 0, 100, 0);
        checkEq("no_stale_frame", firstValid >= 0, 0);
        addFrame(1'b0, 9'h0F0, 9'h1F0);
        runStream(200, 0, 100, 1);
        checkEq("post_reset_outputs", outLog.size(), 4);

        clearTrack();
        addRandomFrames(10);
        runStream(2000, 1, 70, 1);
        checkEq("toggle_outputs", outLog.size(), 40);

        clearTrack();
        addRandomFrames(10);
        runStream(2000, 2, 80, 1);
        checkEq("random_outputs", outLog.size(), 40);
    endtask

    task automatic checkOutput();
        checkEq("final_issue_queue_empty", issueQ.size(), 0);
        checkEq("final_output_queue_empty", outQ.size(), 0);
        checkEq("final_m_valid", m_valid, 0);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
